// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the arithmetic blocks and the accumulator.
// Holds field widths, special encodings and the accumulator state enum.
package fp16_pkg;

    localparam int FP16_W      = 16;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MANT_W = 10;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_INF  = 5'h1F;
    localparam logic [FP16_W-1:0]     FP16_POS_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0]     FP16_QNAN     = 16'h7E00;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/fp16add.sv
// Combinational fp16 adder.
// Ports: i_a, i_b - fp16 operands; o_res - fp16 sum.
// Denormal inputs are treated as zero and underflowing results flush to a
// signed zero. Rounding is to nearest-even using guard/round/sticky bits.
module fp16add
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] i_a,
    input  logic [FP16_W-1:0] i_b,
    output logic [FP16_W-1:0] o_res
);

    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic              s_big, s_sml, sticky, rup;
    logic [4:0]        e_big, e_sml, shamt;
    logic [10:0]       m_big, m_sml;
    logic [14:0]       mag_a, mag_b, sum;
    logic [27:0]       sml_sh;
    logic [13:0]       big_x, aligned, norm;
    logic [11:0]       rnd;
    logic [9:0]        mant_o;
    logic signed [6:0] exp_n;

    always_comb begin
        a_zero  = (i_a[14:10] == 5'd0);
        b_zero  = (i_b[14:10] == 5'd0);
        a_inf   = (i_a[14:10] == FP16_EXP_INF) && (i_a[9:0] == 10'd0);
        b_inf   = (i_b[14:10] == FP16_EXP_INF) && (i_b[9:0] == 10'd0);
        a_nan   = (i_a[14:10] == FP16_EXP_INF) && (i_a[9:0] != 10'd0);
        b_nan   = (i_b[14:10] == FP16_EXP_INF) && (i_b[9:0] != 10'd0);
        mag_a   = a_zero ? 15'd0 : i_a[14:0];
        mag_b   = b_zero ? 15'd0 : i_b[14:0];
        swap    = (mag_b > mag_a);
        s_big   = swap ? i_b[15] : i_a[15];
        s_sml   = swap ? i_a[15] : i_b[15];
        e_big   = swap ? i_b[14:10] : i_a[14:10];
        e_sml   = swap ? i_a[14:10] : i_b[14:10];
        m_big   = {1'b1, (swap ? i_b[9:0] : i_a[9:0])};
        m_sml   = {1'b1, (swap ? i_a[9:0] : i_b[9:0])};
        shamt   = e_big - e_sml;

        // Align the smaller operand; bits shifted past the round position
        // collapse into the sticky bit.
        sml_sh  = {m_sml, 17'd0} >> shamt;
        aligned = sml_sh[27:14];
        sticky  = |sml_sh[13:0];
        if (shamt >= 5'd28) begin
            aligned = 14'd0;
            sticky  = 1'b1;
        end

        big_x = {m_big, 3'b000};
        if (s_big == s_sml) sum = {1'b0, big_x} + {1'b0, aligned};
        else                sum = {1'b0, big_x} - {1'b0, aligned};

        exp_n = $signed({2'b00, e_big});
        if (sum[14]) begin
            norm   = sum[14:1];
            sticky = sticky | sum[0];
            exp_n  = exp_n + 7'sd1;
        end else begin
            norm = sum[13:0];
            for (int i = 0; i < 13; i++) begin
                if (!norm[13] && (norm != 14'd0)) begin
                    norm  = norm << 1;
                    exp_n = exp_n - 7'sd1;
                end
            end
        end

        rup    = norm[2] & (norm[1] | norm[0] | sticky | norm[3]);
        rnd    = {1'b0, norm[13:3]} + {11'd0, rup};
        mant_o = rnd[11] ? rnd[10:1] : rnd[9:0];
        if (rnd[11]) exp_n = exp_n + 7'sd1;

        if (norm == 14'd0)         o_res = FP16_POS_ZERO;
        else if (exp_n >= 7'sd31)  o_res = {s_big, FP16_EXP_INF, 10'd0};
        else if (exp_n <= 7'sd0)   o_res = {s_big, 15'd0};
        else                       o_res = {s_big, exp_n[4:0], mant_o};

        // Special operands take priority over the arithmetic path.
        if (a_nan || b_nan || (a_inf && b_inf && (i_a[15] != i_b[15]))) o_res = FP16_QNAN;
        else if (a_inf)             o_res = i_a;
        else if (b_inf)             o_res = i_b;
        else if (a_zero && b_zero)  o_res = {i_a[15] & i_b[15], 15'd0};
        else if (a_zero)            o_res = i_b;
        else if (b_zero)            o_res = i_a;
    end

endmodule

// File: rtl/fp16_acc.sv
// Streaming fp16 accumulator: sums each group of N consecutive input values
// into one fp16 total and presents it on a valid/ready output.
// Ports: i_clk, i_rst_n (async, active-low); input stream i_data/i_valid/o_ready;
// output stream o_sum/o_valid/i_ready; o_inf flags a partial sum that hit bexp 1F.
// Handshake: a word moves on any rising edge where its valid and ready are both
// high; the sender holds data stable while valid is high and ready is low.
module fp16_acc
    import fp16_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FP16_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [FP16_W-1:0] o_sum,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_inf
);

    localparam int CNT_W = $clog2(N + 1);

    state_e            state_q, state_d;
    logic [FP16_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              inf_q, inf_d;
    logic [FP16_W-1:0] sum_next;
    logic              in_xfer;

    fp16add u_add (
        .i_a   (acc_q),
        .i_b   (i_data),
        .o_res (sum_next)
    );

    // Ready is gated by reset so nothing is offered as accepted while held.
    assign o_ready = (state_q == S_ACC) && i_rst_n;
    assign o_valid = (state_q == S_OUT);
    assign o_sum   = acc_q;
    assign o_inf   = inf_q;
    assign in_xfer = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inf_d   = inf_q;
        case (state_q)
            S_ACC: begin
                if (in_xfer) begin
                    acc_d = sum_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    inf_d = inf_q | (sum_next[14:10] == FP16_EXP_INF);
                    if (cnt_d == CNT_W'(N)) state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    state_d = S_ACC;
                    acc_d   = FP16_POS_ZERO;
                    cnt_d   = '0;
                    inf_d   = 1'b0;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_ACC;
            acc_q   <= FP16_POS_ZERO;
            cnt_q   <= '0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inf_q   <= inf_d;
        end
    end

endmodule

// File: doc/fp16_acc.md
# fp16_acc

Streaming fp16 accumulator that sits directly downstream of the combinational fp16 arithmetic units. It consumes a valid/ready stream of fp16 results, such as `o_res` from `fp16mul`, and sums each group of `N` consecutive values into one fp16 total. It presents that total on a valid/ready output and then starts the next group. All addition is done by one instance of the existing combinational `fp16add` unit, so rounding and special-value handling match that unit.

## Interface
- `N`, default 4: values per group; legal range 1..255.
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  16  fp16 operand {sign, bexp[4:0], mant[9:0]}.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  block accepts `i_data` this cycle.
- `o_sum`  out  16  fp16 group total.
- `o_valid`  out  1  `o_sum` is valid.
- `i_ready`  in  1  consumer accepts `o_sum` this cycle.
- `o_inf`  out  1  some partial sum of the current/presented group had bexp == 5'h1F.

## Operation
- State `S_ACC`:
  - `o_ready` = 1 and `o_valid` = 0.
  - Input transfer: `i_valid & o_ready`.
  - On each input transfer, `acc` <= `fp16add(acc, i_data)` and `cnt` <= `cnt` + 1.
  - On each input transfer, `inf` <= `inf` | (bexp of the new `acc` == 5'h1F).
  - When the transfer that makes `cnt` reach `N` occurs, move to `S_OUT`.
- State `S_OUT`:
  - `o_valid` = 1 and `o_ready` = 0.
  - `o_sum` = `acc` and `o_inf` = `inf`.
  - On `i_ready`, go to `S_ACC` and clear `acc` to 16'h0000, `cnt` to 0 and `inf` to 0.
- `o_sum` and `o_inf` are driven straight from registers, with no combinational path from inputs.
- Starting value of each group:
  - `acc` starts at +0 (16'h0000).
  - A group of only negative zeros therefore gives whatever `fp16add(+0, -0)` returns.
- Special values: Inf/NaN propagation and zero/denormal flushing are delegated to `fp16add`. This block does not inspect them, except to set `inf`.
- `cnt` width is `$clog2(N+1)`. It never wraps, because it is cleared on leaving `S_OUT`.
- `i_data` is ignored whenever no input transfer occurs.

## Timing
- Reset values: state `S_ACC`, `acc` 16'h0000, `cnt` 0, `inf` 0.
  - Outputs after reset: `o_sum` 16'h0000, `o_valid` 0, `o_inf` 0, `o_ready` 1 (while `i_rst_n` is high).
- While `i_rst_n` is low, `o_ready` = 0.
- Latency: `o_valid` rises on the clock edge that accepts the `N`-th input, i.e. one cycle after that transfer.
- Throughput:
  - One input per cycle inside a group.
  - Minimum one cycle in `S_OUT` per group, so the peak rate is `N` inputs per `N+1` cycles.
- Backpressure: while `o_valid` = 1 and `i_ready` = 0, `o_sum` and `o_inf` stay stable and no input is accepted.
- `i_ready` in `S_ACC` has no effect. `i_valid` in `S_OUT` has no effect.
- Reset mid-group or mid-`S_OUT`: any partial group is discarded, all state returns to reset values immediately, and no output is produced for the discarded group.
- `N` = 1: each accepted input produces one output equal to `fp16add(+0, x)`.

## Structure
- Shared package `fp16_pkg` holds:
  - field widths: `FP16_W` = 16, `FP16_EXP_W` = 5, `FP16_MANT_W` = 10;
  - `FP16_EXP_INF` = 5'h1F and `FP16_POS_ZERO` = 16'h0000;
  - the state enum {`S_ACC`, `S_OUT`}.
- One sub-module: the existing `fp16add`, instantiated once with `.i_a(acc)`, `.i_b(i_data)`, `.o_res(sum_next)`.
- Everything else (FSM, counter, handshake) stays in `fp16_acc`.

## Test plan
The bench compares results to expected values with the same ±1-ULP rule (on bits [14:0], sign exact) used for `fp16add`.

- `N` = 4, inputs 3C00, 4000, 4200, 4400 back-to-back with `i_ready` = 1 -> `o_sum` 4900 (10.0), `o_inf` 0, `o_valid` for 1 cycle, one cycle after the 4th transfer.
- `N` = 4, inputs 3C00, BC00, 4000, C000 -> `o_sum` 0000, `o_inf` 0.
- `N` = 2, inputs 7BFF, 7BFF -> `o_sum` 7C00, `o_inf` 1. The next group 3C00, 3C00 -> 4000 with `o_inf` 0.
- Backpressure: first group as in the first scenario, then hold `i_ready` = 0 for 5 cycles while `i_valid` = 1 -> `o_sum` stays 4900, `o_ready` = 0, no input consumed. When `i_ready` rises, the next group starts from 0.
- Reset mid-group: accept 4000, 4000, then pulse `i_rst_n` low -> `o_valid` 0, `o_sum` 0000. Then 3C00 ×4 -> `o_sum` 4400.
- `N` = 1 with `i_valid` held high -> alternating accept/output cycles, each `o_sum` equal to its input for normal values.
